// File: rtl/carry_pipe_adder.sv
// carry_pipe_adder: pipelined post-adder with selectable/registered carry-in.
// The add is split into SEG-bit segments. The carry ripples between segments
// through registers. Operands are skewed in and the result is deskewed out.
module carry_pipe_adder #(
   parameter int unsigned WIDTH      = 48,
   parameter int unsigned SEG        = 12,
   parameter string       CARRYINSEL = "OPMODE5",
   parameter int unsigned CARRYINREG = 1
) (
   input  logic             CLK,
   input  logic             RSTCARRYIN,
   input  logic             CECARRYIN,
   input  logic             CE,
   input  logic             VALID_IN,
   input  logic             OPMODE5,
   input  logic             CARRYIN,
   input  logic             SUB,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] P,
   output logic             CARRYOUT,
   output logic             VALID_OUT
);
   localparam int unsigned SEG_SAFE = (SEG == 0) ? 1 : SEG;
   localparam int unsigned NSEG     = WIDTH / SEG_SAFE;
   localparam logic        SEL_OP5  = (CARRYINSEL == "OPMODE5");
   localparam logic        SEL_CI   = (CARRYINSEL == "CARRYIN");

   // Reject geometries that cannot be split into whole segments
   if (SEG < 1 || (WIDTH % SEG_SAFE) != 0) begin : g_bad_param
      $error("carry_pipe_adder: WIDTH must be a non-zero multiple of SEG");
   end

   logic             cin_sel;
   logic [WIDTH-1:0] a0;
   logic [WIDTH-1:0] b0;
   logic             sub0;
   logic             v0;
   logic             cin0;
   logic [NSEG:0]    carry;
   logic [NSEG-1:0]  v_pipe;

   // Unknown carry-in source names fall through to a constant 0
   assign cin_sel = (SEL_OP5 & OPMODE5) | (SEL_CI & CARRYIN);

   if (CARRYINREG != 0) begin : g_inreg
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;
      logic             sub_q;
      logic             v_q;
      logic             cyi_q;

      // Input stage: operands follow CE, CYI follows CECARRYIN only
      always_ff @(posedge CLK) begin
         if (RSTCARRYIN) begin
            a_q   <= '0;
            b_q   <= '0;
            sub_q <= 1'b0;
            v_q   <= 1'b0;
            cyi_q <= 1'b0;
         end else begin
            if (CE) begin
               a_q   <= A;
               b_q   <= B;
               sub_q <= SUB;
               v_q   <= VALID_IN;
            end
            if (CECARRYIN) begin
               cyi_q <= cin_sel;
            end
         end
      end

      assign a0   = a_q;
      assign b0   = b_q;
      assign sub0 = sub_q;
      assign v0   = v_q;
      assign cin0 = cyi_q;
   end else begin : g_noreg
      assign a0   = A;
      assign b0   = B;
      assign sub0 = SUB;
      assign v0   = VALID_IN;
      assign cin0 = cin_sel;
   end

   // Subtract is A + ~B + ~cin, so the first carry is inverted by SUB
   assign carry[0] = cin0 ^ sub0;

   for (genvar j = 0; j < NSEG; j++) begin : g_seg
      logic [SEG-1:0] a_j;
      logic [SEG-1:0] b_j;
      logic           sub_j;
      logic [SEG:0]   sum_c;
      logic [SEG-1:0] s_q;
      logic           c_q;

      if (j == 0) begin : g_direct
         assign {sub_j, b_j, a_j} = {sub0, b0[SEG-1:0], a0[SEG-1:0]};
      end else begin : g_skew
         logic [2*SEG:0] sk_q [j];

         // Delay this segment's operands by j stages to meet its carry
         always_ff @(posedge CLK) begin
            if (RSTCARRYIN) begin
               for (int i = 0; i < j; i++) begin
                  sk_q[i] <= '0;
               end
            end else if (CE) begin
               sk_q[0] <= {sub0, b0[j*SEG +: SEG], a0[j*SEG +: SEG]};
               for (int i = 1; i < j; i++) begin
                  sk_q[i] <= sk_q[i-1];
               end
            end
         end

         assign {sub_j, b_j, a_j} = sk_q[j-1];
      end

      assign sum_c = {1'b0, a_j} + {1'b0, b_j ^ {SEG{sub_j}}} + (SEG+1)'(carry[j]);

      // Segment adder register: partial sum plus carry into the next segment
      always_ff @(posedge CLK) begin
         if (RSTCARRYIN) begin
            s_q <= '0;
            c_q <= 1'b0;
         end else if (CE) begin
            {c_q, s_q} <= sum_c;
         end
      end

      assign carry[j+1] = c_q;

      if (j == NSEG - 1) begin : g_tail
         assign P[j*SEG +: SEG] = s_q;
      end else begin : g_deskew
         localparam int unsigned D = NSEG - 1 - j;
         logic [SEG-1:0] dk_q [D];

         // Hold early segments back until the top segment finishes
         always_ff @(posedge CLK) begin
            if (RSTCARRYIN) begin
               for (int i = 0; i < int'(D); i++) begin
                  dk_q[i] <= '0;
               end
            end else if (CE) begin
               dk_q[0] <= s_q;
               for (int i = 1; i < int'(D); i++) begin
                  dk_q[i] <= dk_q[i-1];
               end
            end
         end

         assign P[j*SEG +: SEG] = dk_q[D-1];
      end
   end

   // Valid marker travels with the data through every segment stage
   always_ff @(posedge CLK) begin
      if (RSTCARRYIN) begin
         v_pipe <= '0;
      end else if (CE) begin
         v_pipe[0] <= v0;
         for (int i = 1; i < int'(NSEG); i++) begin
            v_pipe[i] <= v_pipe[i-1];
         end
      end
   end

   assign CARRYOUT  = carry[NSEG];
   assign VALID_OUT = v_pipe[NSEG-1];

endmodule

// File: tb/tb_carry_pipe_adder.sv
// Scoreboard bench: three adder configurations share one stimulus stream.
// ch0 = OPMODE5 + CYI reg, ch1 = CARRYIN + CYI reg, ch2 = illegal sel, no reg.
module tb_carry_pipe_adder;
   localparam int unsigned W   = 48;
   localparam int unsigned NS  = 4;
   localparam int          NCH = 3;

   typedef struct packed {
      logic [W-1:0] p;
      logic         co;
      int unsigned  due;
   } exp_t;

   logic         clk;
   logic         rst;
   logic         ceci;
   logic         ce;
   logic         vin;
   logic         op5;
   logic         cin_in;
   logic         sub;
   logic [W-1:0] a;
   logic [W-1:0] b;

   logic [W-1:0] p_o  [NCH];
   logic         co_o [NCH];
   logic         vo_o [NCH];

   exp_t         sb [NCH][$];
   logic         cyi_m [NCH];
   logic         last_v [NCH];
   logic [W-1:0] last_p [NCH];
   logic         last_co [NCH];

   int unsigned  ce_cnt   = 0;
   bit           adv      = 1'b0;
   bit           rst_seen = 1'b0;
   int unsigned  n_chk    = 0;
   int unsigned  n_pass   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   carry_pipe_adder #(.WIDTH(W), .SEG(12), .CARRYINSEL("OPMODE5"), .CARRYINREG(1)) u_op5 (
      .CLK(clk), .RSTCARRYIN(rst), .CECARRYIN(ceci), .CE(ce), .VALID_IN(vin),
      .OPMODE5(op5), .CARRYIN(cin_in), .SUB(sub), .A(a), .B(b),
      .P(p_o[0]), .CARRYOUT(co_o[0]), .VALID_OUT(vo_o[0]));

   carry_pipe_adder #(.WIDTH(W), .SEG(12), .CARRYINSEL("CARRYIN"), .CARRYINREG(1)) u_ci (
      .CLK(clk), .RSTCARRYIN(rst), .CECARRYIN(ceci), .CE(ce), .VALID_IN(vin),
      .OPMODE5(op5), .CARRYIN(cin_in), .SUB(sub), .A(a), .B(b),
      .P(p_o[1]), .CARRYOUT(co_o[1]), .VALID_OUT(vo_o[1]));

   carry_pipe_adder #(.WIDTH(W), .SEG(12), .CARRYINSEL("NONE"), .CARRYINREG(0)) u_none (
      .CLK(clk), .RSTCARRYIN(rst), .CECARRYIN(ceci), .CE(ce), .VALID_IN(vin),
      .OPMODE5(op5), .CARRYIN(cin_in), .SUB(sub), .A(a), .B(b),
      .P(p_o[2]), .CARRYOUT(co_o[2]), .VALID_OUT(vo_o[2]));

   // Plain-arithmetic reference: add, or subtract with carry-out = no borrow
   function automatic void ref_op(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                  input logic rsub, input logic rcin,
                                  output logic [W-1:0] rp, output logic rco);
      longint unsigned t;
      if (!rsub) begin
         t   = 64'(ra) + 64'(rb) + 64'(rcin);
         rp  = t[W-1:0];
         rco = t[W];
      end else begin
         t   = 64'(ra) - 64'(rb) - 64'(rcin);
         rp  = t[W-1:0];
         rco = (64'(ra) >= 64'(rb) + 64'(rcin));
      end
   endfunction

   function automatic int unsigned lat_of(input int c);
      return (c == 2) ? NS : NS + 1;
   endfunction

   task automatic chk(input string nm, input int c, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s ch%0d: got %h expected %h at %0t", nm, c, got, exp, $time);
   endtask

   // Issue side: record each operation the DUT captures on a CE edge
   logic cin_now;
   logic cin_use;
   exp_t e_m;
   always @(posedge clk) begin
      for (int c = 0; c < NCH; c++) begin
         if (rst) begin
            cyi_m[c] = 1'b0;
            sb[c].delete();
         end else begin
            cin_now = (c == 0) ? op5 : (c == 1) ? cin_in : 1'b0;
            if (c != 2) begin
               if (ceci) cyi_m[c] = cin_now;
               cin_use = cyi_m[c];
            end else begin
               cin_use = cin_now;
            end
            if (ce && vin) begin
               ref_op(a, b, sub, cin_use, e_m.p, e_m.co);
               e_m.due = ce_cnt + lat_of(c);
               sb[c].push_back(e_m);
            end
         end
      end
      if (rst) begin
         adv = 1'b0;
      end else begin
         adv = ce;
         if (ce) ce_cnt++;
      end
      rst_seen = rst;
   end

   // Monitor: compare outputs mid-cycle against the scoreboard
   exp_t e_c;
   logic exp_v;
   always @(negedge clk) begin
      for (int c = 0; c < NCH; c++) begin
         if (rst_seen) begin
            chk("reset_valid", c, W'(vo_o[c]), '0);
            chk("reset_p", c, p_o[c], '0);
            chk("reset_carryout", c, W'(co_o[c]), '0);
            last_v[c]  = 1'b0;
            last_p[c]  = '0;
            last_co[c] = 1'b0;
         end else if (adv) begin
            exp_v = 1'b0;
            if (sb[c].size() > 0 && sb[c][0].due < ce_cnt) begin
               e_c = sb[c].pop_front();
               chk("missed_result", c, W'(ce_cnt), W'(e_c.due));
            end
            if (sb[c].size() > 0 && sb[c][0].due == ce_cnt) begin
               e_c   = sb[c].pop_front();
               exp_v = 1'b1;
            end
            chk("valid", c, W'(vo_o[c]), W'(exp_v));
            if (exp_v) begin
               chk("p", c, p_o[c], e_c.p);
               chk("carryout", c, W'(co_o[c]), W'(e_c.co));
               last_p[c]  = e_c.p;
               last_co[c] = e_c.co;
            end
            last_v[c] = exp_v;
         end else begin
            chk("stall_valid", c, W'(vo_o[c]), W'(last_v[c]));
            if (last_v[c]) begin
               chk("stall_p", c, p_o[c], last_p[c]);
               chk("stall_carryout", c, W'(co_o[c]), W'(last_co[c]));
            end
         end
      end
   end

   task automatic drive(input logic [W-1:0] da, input logic [W-1:0] db, input logic dsub,
                        input logic dop5, input logic dci, input logic dv);
      a = da; b = db; sub = dsub; op5 = dop5; cin_in = dci; vin = dv;
      @(negedge clk);
   endtask

   task automatic drive_rand();
      logic [63:0] ra;
      logic [63:0] rb;
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      if ($urandom_range(0, 7) == 0) ra = '1;
      drive(ra[W-1:0], rb[W-1:0], 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive('0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b1; ce = 1'b1; ceci = 1'b1; vin = 1'b0;
      sub = 1'b0; op5 = 1'b0; cin_in = 1'b0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // full ripple through all segments, wrap to zero
      drive(48'hFFFF_FFFF_FFFF, 48'h0, 1'b0, 1'b1, 1'b0, 1'b1);
      idle(7);

      // subtract with and without borrow
      drive(48'd5, 48'd7, 1'b1, 1'b0, 1'b0, 1'b1);
      drive(48'd7, 48'd5, 1'b1, 1'b0, 1'b0, 1'b1);
      idle(7);

      // illegal selector ignores both carry candidates
      drive(48'd1, 48'd1, 1'b0, 1'b1, 1'b1, 1'b1);
      idle(7);

      // random stream with a CE stall and a frozen CYI window
      for (int i = 0; i < 100; i++) begin
         ceci = !(i >= 47 && i < 57);
         ce   = !(i >= 50 && i < 53);
         drive_rand();
      end
      ce = 1'b1; ceci = 1'b1;
      idle(8);

      // reset with three operations in flight, valid input during reset
      drive_rand();
      drive_rand();
      drive_rand();
      rst = 1'b1;
      drive_rand();
      rst = 1'b0;
      drive_rand();
      drive_rand();
      idle(10);

      for (int c = 0; c < NCH; c++) begin
         chk("drained", c, W'(sb[c].size()), '0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/carry_pipe_adder.md
# carry_pipe_adder

Parametrised, pipelined post-adder with integrated carry-in selection for the DSP48A1 slice family. Selects the carry-in from OPMODE5 or the CARRYIN port, optionally registers it as CYI, then adds or subtracts two WIDTH-bit operands in SEG-bit segments. The carry ripples between segments through pipeline registers, so wide adds close timing at full slice rate. It sits after the multiplier/pre-adder path and drives P and CARRYOUT.

## Interface
- WIDTH, 48: operand and result width; must be a multiple of SEG.
- SEG, 12: bits added per pipeline stage; NSEG = WIDTH/SEG.
- CARRYINSEL, "OPMODE5": carry-in source.
  - "OPMODE5" selects the OPMODE5 port; "CARRYIN" selects the CARRYIN port.
  - Any other value forces carry-in to 0.
- CARRYINREG, 1: 1 = registered CYI stage; 0 = carry-in is combinational into stage 1.

- CLK  in  1  sole clock; all registers update on its rising edge.
- RSTCARRYIN  in  1  synchronous, active-high reset for every register in the block.
- CECARRYIN  in  1  clock enable for the CYI register only.
- CE  in  1  clock enable for all segment, skew, deskew and valid registers.
- VALID_IN  in  1  qualifies the inputs A, B, SUB, OPMODE5 and CARRYIN.
- OPMODE5  in  1  carry-in candidate.
- CARRYIN  in  1  carry-in candidate.
- SUB  in  1  0 = add, 1 = subtract.
- A  in  WIDTH  minuend / augend.
- B  in  WIDTH  subtrahend / addend.
- P  out  WIDTH  result.
- CARRYOUT  out  1  carry out of bit WIDTH-1.
- VALID_OUT  out  1  P and CARRYOUT are valid this cycle.

## Operation
- Carry select
  - cin = OPMODE5 or CARRYIN per CARRYINSEL, else 0.
  - With CARRYINREG=1, CYI captures cin when CECARRYIN=1 and holds otherwise.
  - With CARRYINREG=1, the A/B/SUB/VALID_IN input register also advances on CE, keeping operands aligned with CYI.
- Arithmetic
  - Computes A + (B XOR {WIDTH{SUB}}) + (cin XOR SUB), modulo 2^WIDTH.
  - SUB=0 gives P = A+B+cin.
  - SUB=1 gives P = A−B−cin, and CARRYOUT=1 means no borrow.
- Segmentation
  - Stage k (k = 1..NSEG) adds bits [k·SEG−1:(k−1)·SEG] plus the carry registered by stage k−1; stage 1 uses cin.
  - Upper segments of A/B/SUB are skewed through k−1 delay registers.
  - Lower result segments are deskewed so that all of P emerges in the same cycle.
  - CARRYOUT is the stage-NSEG carry, aligned with P.
- CE=0 freezes every pipeline register, including VALID; no data is dropped or duplicated. CE has no effect on CYI.
- VALID_IN travels alongside the data. Data advances whether or not VALID_IN is set; VALID only marks it.
- Elaboration must fail if WIDTH % SEG ≠ 0 or SEG < 1.

## Timing
- Latency L = NSEG + CARRYINREG cycles from input to P/CARRYOUT/VALID_OUT, counted in CE-enabled cycles.
- Throughput is one operation per CE cycle.
- Reset values: P=0, CARRYOUT=0, VALID_OUT=0, CYI=0, all internal pipeline registers 0.
- Reset dominates CE and CECARRYIN.
- Reset asserted mid-operation discards every in-flight operation. The first valid output after reset deasserts appears L CE-cycles after the first VALID_IN.
- Simultaneous RSTCARRYIN and VALID_IN: the input is discarded.
- CE=0 on the cycle an output becomes valid: P and VALID_OUT hold their current values until CE returns.
- Wrap-around: an all-ones + 1 result gives P=0 and CARRYOUT=1. No saturation.

## Test plan
- Full ripple (WIDTH=48, SEG=12, CARRYINREG=1, CARRYINSEL="OPMODE5"): A=0xFFFFFFFFFFFF, B=0, OPMODE5=1, SUB=0 → after 5 cycles P=0, CARRYOUT=1, VALID_OUT=1.
- Subtract with borrow (CARRYINSEL="CARRYIN", CARRYIN=0): A=5, B=7, SUB=1 → P=0xFFFFFFFFFFFE, CARRYOUT=0. Then A=7, B=5 → P=2, CARRYOUT=1.
- Back-to-back stream: 100 random A/B/SUB/cin vectors with VALID_IN held high → each P matches the reference model exactly L cycles later. Also verify that the CARRYOUT stream and the VALID_OUT stream each match.
- CE stall: deassert CE for 3 cycles mid-stream → outputs freeze, then resume with no gaps or repeats. With CECARRYIN=0, CYI holds its stale value, and the bench checks that the stale carry is used.
- Reset mid-flight: RSTCARRYIN for 1 cycle with 3 operations in flight → P=0 and VALID_OUT=0 next cycle; none of the discarded results ever appears.
- Illegal CARRYINSEL="NONE" with CARRYINREG=0: A=1, B=1, OPMODE5=1, CARRYIN=1 → P=2 after 4 cycles.
